// File: rtl/lift_call_ctrl.sv
// Four-floor lift call controller: latches call buttons, picks targets by SCAN, holds the door for DWELL_CYCLES.
// Optional build macro LIFT_CALL_DEBOUNCE_EN adds a two-sample debounce on every call button.
module lift_call_ctrl #(
    parameter int DWELL_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] call_btn,
    input  logic [1:0] lift_state,
    output logic [1:0] floor,
    output logic [3:0] pending,
    output logic       door_open,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, MOVE, DWELL} state_e;

    localparam logic [3:0] DWELL_LOAD = 4'(DWELL_CYCLES - 1);

    state_e     state_q, state_d;
    logic       dir_q, dir_d;
    logic [1:0] floor_q, floor_d;
    logic [3:0] pend_q, pend_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] cap;
    logic [2:0] sel;
    int         ls, fl;

`ifdef LIFT_CALL_DEBOUNCE_EN
    logic [3:0] db1_q, db2_q;

    // A call only counts once the button has been seen high on two consecutive edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db1_q <= 4'b0;
            db2_q <= 4'b0;
        end else begin
            db1_q <= call_btn;
            db2_q <= db1_q;
        end
    end

    assign cap = db1_q & db2_q;
`else
    assign cap = call_btn;
`endif

    // Returns {found, floor} for the lowest (or highest) pending floor within [lo, hi].
    function automatic logic [2:0] pick(input logic [3:0] p, input int lo, input int hi,
                                        input logic want_high);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 0; i < 4; i++) begin
            if (p[i] && i >= lo && i <= hi && (want_high || !r[2]))
                r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        floor_d = floor_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q | cap;
        sel     = 3'b000;
        ls      = int'(lift_state);
        fl      = int'(floor_q);
        case (state_q)
            IDLE: begin
                if (pend_q != 4'b0) begin
                    if (!dir_q) begin
                        sel = pick(pend_q, ls, 3, 1'b0);
                        if (!sel[2]) begin
                            sel   = pick(pend_q, 0, ls - 1, 1'b1);
                            dir_d = 1'b1;
                        end
                    end else begin
                        sel = pick(pend_q, 0, ls, 1'b1);
                        if (!sel[2]) begin
                            sel   = pick(pend_q, ls + 1, 3, 1'b0);
                            dir_d = 1'b0;
                        end
                    end
                    floor_d = sel[1:0];
                    state_d = MOVE;
                end
            end
            MOVE: begin
                if (lift_state == floor_q) begin
                    pend_d[floor_q] = 1'b0;
                    cnt_d           = DWELL_LOAD;
                    state_d         = DWELL;
                end else begin
                    // Intercept: a call strictly between car and target, nearest the car, wins.
                    sel = dir_q ? pick(pend_q, fl + 1, ls - 1, 1'b1)
                                : pick(pend_q, ls + 1, fl - 1, 1'b0);
                    if (sel[2])
                        floor_d = sel[1:0];
                end
            end
            DWELL: begin
                pend_d[floor_q] = 1'b0;
                if (cnt_q == 4'd0)
                    state_d = IDLE;
                else
                    cnt_d = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            floor_q <= 2'd0;
            pend_q  <= 4'b0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            floor_q <= floor_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    assign floor     = floor_q;
    assign pending   = pend_q;
    assign door_open = (state_q == DWELL);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_lift_call_ctrl.sv
// Bench for lift_call_ctrl: directed scenarios with literal expectations plus a random lift plant
// checked every cycle against a behavioural model of the call/SCAN/dwell rules.
module tb_lift_call_ctrl;
    localparam int DW = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] call_btn = 4'b0;
    logic [1:0] lift_state = 2'd0;
    logic [1:0] floor;
    logic [3:0] pending;
    logic       door_open;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: mode 0 = waiting, 1 = travelling, 2 = door open; m_left = door cycles remaining.
    int       m_mode, m_tgt, m_left;
    bit       m_down;
    bit [3:0] m_pend, m_h1, m_h2;

    always #5 clk = ~clk;

    lift_call_ctrl #(.DWELL_CYCLES(DW)) dut (
        .clk(clk), .reset(reset), .call_btn(call_btn), .lift_state(lift_state),
        .floor(floor), .pending(pending), .door_open(door_open), .busy(busy)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_tgt = 0; m_left = 0; m_down = 0;
        m_pend = 4'b0; m_h1 = 4'b0; m_h2 = 4'b0;
    endtask

    task automatic model_step();
        bit [3:0] cap, nxt;
        int ls;
        bit found;
        if (!reset) begin
            model_reset();
            return;
        end
`ifdef LIFT_CALL_DEBOUNCE_EN
        cap  = m_h1 & m_h2;
        m_h2 = m_h1;
        m_h1 = call_btn;
`else
        cap = call_btn;
`endif
        ls    = int'(lift_state);
        nxt   = m_pend | cap;
        found = 0;
        if (m_mode == 0) begin
            if (m_pend != 0) begin
                if (!m_down) begin
                    for (int f = ls; f <= 3 && !found; f++)
                        if (m_pend[f]) begin m_tgt = f; found = 1; end
                    if (!found) begin
                        m_down = 1;
                        for (int f = ls - 1; f >= 0 && !found; f--)
                            if (m_pend[f]) begin m_tgt = f; found = 1; end
                    end
                end else begin
                    for (int f = ls; f >= 0 && !found; f--)
                        if (m_pend[f]) begin m_tgt = f; found = 1; end
                    if (!found) begin
                        m_down = 0;
                        for (int f = ls + 1; f <= 3 && !found; f++)
                            if (m_pend[f]) begin m_tgt = f; found = 1; end
                    end
                end
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (ls == m_tgt) begin
                nxt[m_tgt] = 1'b0;
                m_left = DW;
                m_mode = 2;
            end else if (!m_down) begin
                for (int f = ls + 1; f < m_tgt && !found; f++)
                    if (m_pend[f]) begin m_tgt = f; found = 1; end
            end else begin
                for (int f = ls - 1; f > m_tgt && !found; f--)
                    if (m_pend[f]) begin m_tgt = f; found = 1; end
            end
        end else begin
            nxt[m_tgt] = 1'b0;
            m_left--;
            if (m_left == 0) m_mode = 0;
        end
        m_pend = nxt;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge reset);
        model_reset();
    end

    initial forever begin
        @(negedge clk);
        check("floor", int'(floor), m_tgt);
        check("pending", int'(pending), int'(m_pend));
        check("door_open", int'(door_open), (m_mode == 2) ? 1 : 0);
        check("busy", int'(busy), (m_mode != 0) ? 1 : 0);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 40) begin
            step();
            k++;
        end
        check(name, int'(busy), 0);
    endtask

    initial begin
        int cnt, ls;
        model_reset();
        repeat (2) step();
        check("rst_floor", int'(floor), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_door", int'(door_open), 0);
        reset = 1'b1;
`ifndef LIFT_CALL_DEBOUNCE_EN
        // Single call from floor 0 to floor 3.
        call_btn = 4'b1000; step();
        check("cap_pending", int'(pending), 8);
        check("cap_busy", int'(busy), 0);
        call_btn = 4'b0; step();
        check("single_floor", int'(floor), 3);
        check("single_busy", int'(busy), 1);
        check("model_tgt", m_tgt, 3);
        lift_state = 2'd3;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (door_open) cnt++;
        end
        check("dwell_len", cnt, 4);
        check("single_done_pend", int'(pending), 0);
        check("single_done_busy", int'(busy), 0);

        // SCAN: up sweep first, then reverse.
        lift_state = 2'd1; call_btn = 4'b1001; step();
        call_btn = 4'b0; step();
        check("scan_first", int'(floor), 3);
        lift_state = 2'd3; step();
        check("scan_door", int'(door_open), 1);
        wait_idle("scan_idle1");
        step();
        check("scan_second", int'(floor), 0);
        check("model_dir_down", int'(m_down), 1);
        lift_state = 2'd0;
        wait_idle("scan_idle2");

        // Intercept on the way up, then door-time button masking.
        call_btn = 4'b1000; step();
        call_btn = 4'b0; step();
        check("icpt_start", int'(floor), 3);
        lift_state = 2'd1; call_btn = 4'b0100; step();
        call_btn = 4'b0;
        check("icpt_hold", int'(floor), 3);
        check("icpt_pend", int'(pending), 12);
        step();
        check("icpt_floor", int'(floor), 2);
        lift_state = 2'd2; call_btn = 4'b0101; step();
        check("arrive_clear", int'(pending), 9);
        cnt = 0;
        while (door_open && cnt < 20) begin
            check("dwell_mask", int'(pending[2]), 0);
            step();
            cnt++;
        end
        call_btn = 4'b0;
        check("dwell_len2", cnt, 4);
        check("after_dwell_pend", int'(pending), 9);
        step();
        check("after_dwell_tgt", int'(floor), 3);
        lift_state = 2'd3;
        wait_idle("icpt_idle1");
        step();
        check("icpt_last", int'(floor), 0);
        lift_state = 2'd0;
        wait_idle("icpt_idle2");

        // Asynchronous reset while travelling.
        call_btn = 4'b1000; step();
        call_btn = 4'b0; step();
        check("pre_rst_floor", int'(floor), 3);
        check("pre_rst_busy", int'(busy), 1);
        #2 reset = 1'b0;
        #1;
        check("async_floor", int'(floor), 0);
        check("async_pending", int'(pending), 0);
        check("async_busy", int'(busy), 0);
        check("async_door", int'(door_open), 0);
        step();
        reset = 1'b1;
`else
        // Glitch rejection and two-sample capture.
        call_btn = 4'b0010; step();
        call_btn = 4'b0;
        repeat (3) step();
        check("db_glitch", int'(pending), 0);
        call_btn = 4'b0010; step();
        step();
        call_btn = 4'b0;
        check("db_wait", int'(pending), 0);
        step();
        check("db_set", int'(pending), 2);
`endif
        // Random traffic with a simple lift plant chasing the model's target.
        for (int c = 0; c < 3000; c++) begin
            step();
            reset = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 3) == 0)
                call_btn = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15))
                         & 4'($urandom_range(0, 15));
            ls = int'(lift_state);
            if ($urandom_range(0, 99) == 0)
                ls = int'($urandom_range(0, 3));
            else if (m_mode == 1 && $urandom_range(0, 2) == 0)
                ls = (m_tgt > ls) ? ls + 1 : (m_tgt < ls) ? ls - 1 : ls;
            lift_state = 2'(ls);
        end
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
